seg7_periph: RTL and testbench

Bus-mapped four-digit seven-segment display peripheral. Sits on the processor data/address bus and drives the board pins `SEG_SELECT_OUT` and `HEX_OUT` directly. It holds four hex digits, a decimal-point mask and an enable bit in bus-writable registers. It time-multiplexes the digits with a free-running scan counter on the system clock.

---
 rtl/seg7_pkg.sv | 47 ++++
 rtl/seg7_periph_if.sv | 22 ++
 rtl/seg7_scan.sv | 46 ++++
 rtl/seg7_periph.sv | 158 +++++++++++++++
 tb/tb_seg7_periph.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the seven-segment display peripheral.
// Holds the register offsets, the CTRL reset value, the register-file
// struct and the hex-to-segment decode table (active-low {g..a}).
package seg7_pkg;

  // Register offsets from BASE_ADDR
  localparam logic [1:0] DIG_LO  = 2'd0;
  localparam logic [1:0] DIG_HI  = 2'd1;
  localparam logic [1:0] DP_MASK = 2'd2;
  localparam logic [1:0] CTRL    = 2'd3;

  // Display is enabled out of reset
  localparam logic [7:0] CTRL_RST = 8'h01;

  // Architectural register state; unused register bits are not stored
  typedef struct packed {
    logic [7:0] dig_lo;   // [3:0] digit0, [7:4] digit1
    logic [7:0] dig_hi;   // [3:0] digit2, [7:4] digit3
    logic [3:0] dp_mask;  // decimal point per digit, 1 = lit
    logic       en;       // 0 = blank all
  } regs_t;

  // Active-low segment pattern {g,f,e,d,c,b,a} for a hex nibble
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_periph_if.sv
// seg7_periph_if: processor bus address/strobe bundle for the display peripheral.
// Ports: BUS_ADDR (8b address), BUS_WE (write strobe, one cycle).
// The bidirectional data lines stay a plain inout net on the peripheral, since
// the read driver is a tri-state that resolves on the board-level net.
interface seg7_periph_if;

  logic [7:0] BUS_ADDR;
  logic       BUS_WE;

  // Processor side drives address and strobe
  modport master (
    output BUS_ADDR,
    output BUS_WE
  );

  // Peripheral side samples them
  modport slave (
    input BUS_ADDR,
    input BUS_WE
  );

endinterface

// File: rtl/seg7_scan.sv
// seg7_scan: free-running digit scan timer.
// Ports: clk_i, rst_i (sync, active-high); digit_idx_o selects the digit being
// shown, digit_adv_o pulses for one cycle in the last tick of each digit slot.
// Each digit slot lasts exactly DIGIT_TICKS cycles; digit 3 wraps to 0 directly.
module seg7_scan #(
  parameter int DIGIT_TICKS = 12500
) (
  input  logic       clk_i,
  input  logic       rst_i,
  output logic [1:0] digit_idx_o,
  output logic       digit_adv_o
);

  localparam int TW = (DIGIT_TICKS > 2) ? $clog2(DIGIT_TICKS) : 1;
  localparam logic [TW-1:0] LAST_TICK = TW'(DIGIT_TICKS - 1);

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [1:0]    digit_idx_q, digit_idx_d;
  logic          wrap;

  assign wrap = (tick_cnt_q == LAST_TICK);

  always_comb begin
    tick_cnt_d  = tick_cnt_q + TW'(1);
    digit_idx_d = digit_idx_q;
    if (wrap) begin
      tick_cnt_d  = '0;
      // 2-bit index rolls 3 -> 0 naturally
      digit_idx_d = digit_idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tick_cnt_q  <= '0;
      digit_idx_q <= 2'd0;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      digit_idx_q <= digit_idx_d;
    end
  end

  assign digit_idx_o = digit_idx_q;
  assign digit_adv_o = wrap;

endmodule

// File: rtl/seg7_periph.sv
// seg7_periph: bus-mapped four-digit seven-segment display peripheral.
// Ports: CLK, RESET (sync, active-high); bus (address/strobe interface),
// BUS_DATA (inout, driven only in the cycle after a read); SEG_SELECT_OUT
// (active-low anodes), HEX_OUT (active-low cathodes, [7]=dp, [6:0]=g..a).
// Registers at BASE_ADDR..BASE_ADDR+3; pins are registered, so they follow the
// scan index and register writes by one cycle.
module seg7_periph
  import seg7_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR   = 8'hD0,
  parameter int         DIGIT_TICKS = 12500
) (
  input  logic                CLK,
  input  logic                RESET,
  seg7_periph_if.slave        bus,
  inout  wire  [7:0]          BUS_DATA,
  output logic [3:0]          SEG_SELECT_OUT,
  output logic [7:0]          HEX_OUT
);

  // ------------------------------------------------------------------
  // Address decode
  // ------------------------------------------------------------------
  // Compare in 9 bits so a base near 8'hFF cannot wrap the window.
  logic [8:0] addr_ext;
  logic [8:0] base_ext;
  logic       in_range;
  logic [1:0] reg_off;
  logic       wr_en;
  logic       rd_en;

  assign addr_ext = {1'b0, bus.BUS_ADDR};
  assign base_ext = {1'b0, BASE_ADDR};
  assign in_range = (addr_ext >= base_ext) && (addr_ext <= base_ext + 9'd3);
  assign reg_off  = bus.BUS_ADDR[1:0] - BASE_ADDR[1:0];
  assign wr_en    = in_range && bus.BUS_WE;
  assign rd_en    = in_range && !bus.BUS_WE;

  // ------------------------------------------------------------------
  // Register file
  // ------------------------------------------------------------------
  regs_t regs_q, regs_d;

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      case (reg_off)
        DIG_LO:  regs_d.dig_lo  = BUS_DATA;
        DIG_HI:  regs_d.dig_hi  = BUS_DATA;
        DP_MASK: regs_d.dp_mask = BUS_DATA[3:0];
        default: regs_d.en      = BUS_DATA[0];
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      regs_q.dig_lo  <= 8'h00;
      regs_q.dig_hi  <= 8'h00;
      regs_q.dp_mask <= 4'h0;
      regs_q.en      <= CTRL_RST[0];
    end else begin
      regs_q <= regs_d;
    end
  end

  // ------------------------------------------------------------------
  // Registered read and tri-state driver
  // ------------------------------------------------------------------
  logic       rd_vld_q, rd_vld_d;
  logic [7:0] rd_dat_q, rd_dat_d;

  // Read data comes from the current register state; a write on the previous
  // edge is therefore already visible to an immediately following read.
  always_comb begin
    rd_vld_d = rd_en;
    case (reg_off)
      DIG_LO:  rd_dat_d = regs_q.dig_lo;
      DIG_HI:  rd_dat_d = regs_q.dig_hi;
      DP_MASK: rd_dat_d = {4'h0, regs_q.dp_mask};
      default: rd_dat_d = {7'h00, regs_q.en};
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd_vld_q <= 1'b0;
      rd_dat_q <= 8'h00;
    end else begin
      rd_vld_q <= rd_vld_d;
      rd_dat_q <= rd_dat_d;
    end
  end

  assign BUS_DATA = rd_vld_q ? rd_dat_q : 8'hzz;

  // ------------------------------------------------------------------
  // Digit scan
  // ------------------------------------------------------------------
  logic [1:0] digit_idx;
  logic       digit_adv;

  seg7_scan #(
    .DIGIT_TICKS (DIGIT_TICKS)
  ) u_scan (
    .clk_i       (CLK),
    .rst_i       (RESET),
    .digit_idx_o (digit_idx),
    .digit_adv_o (digit_adv)
  );

  // The output stage re-decodes every cycle, so the slot boundary pulse is
  // not needed here; it stays available on the scan block for other users.
  logic unused_digit_adv;
  assign unused_digit_adv = digit_adv;

  // ------------------------------------------------------------------
  // Output stage
  // ------------------------------------------------------------------
  logic [3:0] nibble;
  logic       dp_lit;
  logic [3:0] seg_sel_q, seg_sel_d;
  logic [7:0] hex_q, hex_d;

  always_comb begin
    case (digit_idx)
      2'd0:    nibble = regs_q.dig_lo[3:0];
      2'd1:    nibble = regs_q.dig_lo[7:4];
      2'd2:    nibble = regs_q.dig_hi[3:0];
      default: nibble = regs_q.dig_hi[7:4];
    endcase
    dp_lit = regs_q.dp_mask[digit_idx];

    // Blanking only masks the pins; the scan keeps its phase underneath
    if (regs_q.en) begin
      seg_sel_d = ~(4'b0001 << digit_idx);
      hex_d     = {~dp_lit, hex_to_seg(nibble)};
    end else begin
      seg_sel_d = 4'hF;
      hex_d     = 8'hFF;
    end
  end

  // Reset value matches digit0 showing "0" with dp off
  always_ff @(posedge CLK) begin
    if (RESET) begin
      seg_sel_q <= 4'hE;
      hex_q     <= 8'hC0;
    end else begin
      seg_sel_q <= seg_sel_d;
      hex_q     <= hex_d;
    end
  end

  assign SEG_SELECT_OUT = seg_sel_q;
  assign HEX_OUT        = hex_q;

endmodule

// File: tb/tb_seg7_periph.sv
// Bench for seg7_periph with DIGIT_TICKS=4: directed steps from the test plan
// followed by random bus traffic, all checked every cycle against a reference
// model based on edge counting. A pullup makes an undriven BUS_DATA read 8'hFF.
module tb_seg7_periph;

  localparam int         DT   = 4;
  localparam logic [7:0] BASE = 8'hD0;

  // Reference segment table, active-low {g..a}
  localparam logic [6:0] SEG_TBL [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg7_periph_if bus_if ();

  wire  [7:0] bus_data;
  logic [7:0] drv_dat;
  logic       drv_oe;
  assign bus_data = drv_oe ? drv_dat : 8'hzz;

  for (genvar g = 0; g < 8; g++) begin : g_pull
    pullup (bus_data[g]);
  end

  logic [3:0] sel;
  logic [7:0] hex;

  seg7_periph #(
    .BASE_ADDR   (BASE),
    .DIGIT_TICKS (DT)
  ) dut (
    .CLK            (clk),
    .RESET          (rst),
    .bus            (bus_if),
    .BUS_DATA       (bus_data),
    .SEG_SELECT_OUT (sel),
    .HEX_OUT        (hex)
  );

  // ---------------- reference model ----------------
  logic [3:0]  m_dig [4];
  logic [3:0]  m_dp;
  logic        m_en;
  int unsigned m_edges;
  bit          m_valid = 1'b0;
  int          m_d;
  int          m_off;
  logic [3:0]  exp_sel;
  logic [7:0]  exp_hex;
  logic [7:0]  exp_bus;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
      m_dp    = 4'h0;
      m_en    = 1'b1;
      m_edges = 0;
      exp_sel = 4'hE;
      exp_hex = 8'hC0;
      exp_bus = 8'hFF;
      m_valid = 1'b1;
    end else begin
      // digit in its slot during the previous cycle
      m_d = int'((m_edges / DT) % 4);
      if (m_en) begin
        exp_sel = 4'hF;
        exp_sel[m_d] = 1'b0;
        exp_hex = {~m_dp[m_d], SEG_TBL[m_dig[m_d]]};
      end else begin
        exp_sel = 4'hF;
        exp_hex = 8'hFF;
      end
      exp_bus = 8'hFF;
      if (int'(bus_if.BUS_ADDR) >= int'(BASE) && int'(bus_if.BUS_ADDR) <= int'(BASE) + 3) begin
        m_off = int'(bus_if.BUS_ADDR) - int'(BASE);
        if (bus_if.BUS_WE) begin
          case (m_off)
            0: begin m_dig[0] = drv_dat[3:0]; m_dig[1] = drv_dat[7:4]; end
            1: begin m_dig[2] = drv_dat[3:0]; m_dig[3] = drv_dat[7:4]; end
            2: m_dp = drv_dat[3:0];
            default: m_en = drv_dat[0];
          endcase
        end else begin
          case (m_off)
            0: exp_bus = {m_dig[1], m_dig[0]};
            1: exp_bus = {m_dig[3], m_dig[2]};
            2: exp_bus = {4'h0, m_dp};
            default: exp_bus = {7'h00, m_en};
          endcase
        end
      end
      m_edges++;
    end
  end

  // ---------------- checking / stimulus ----------------
  int n_assert = 0;
  int n_fail   = 0;
  bit last_rd  = 1'b0;

  task automatic chk(input string tag);
    if (m_valid) begin
      n_assert++;
      assert (sel === exp_sel) else begin
        n_fail++;
        $error("FAIL %s sel: got %h expected %h", tag, sel, exp_sel);
      end
      n_assert++;
      assert (hex === exp_hex) else begin
        n_fail++;
        $error("FAIL %s hex: got %h expected %h", tag, hex, exp_hex);
      end
      if (!drv_oe) begin
        n_assert++;
        assert (bus_data === exp_bus) else begin
          n_fail++;
          $error("FAIL %s bus_data: got %h expected %h", tag, bus_data, exp_bus);
        end
      end
    end
  endtask

  // One clock: check the outputs of the previous edge, then drive the next inputs
  task automatic cyc(input logic r, input logic we, input logic [7:0] a,
                     input logic [7:0] d, input string tag);
    @(negedge clk);
    chk(tag);
    rst            = r;
    bus_if.BUS_WE   = we;
    bus_if.BUS_ADDR = a;
    drv_oe         = we;
    drv_dat        = d;
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00, 8'h00, tag);
  endtask

  task automatic wr(input int off, input logic [7:0] d, input string tag);
    cyc(1'b0, 1'b1, BASE + 8'(off), d, tag);
  endtask

  task automatic rd(input int off, input string tag);
    cyc(1'b0, 1'b0, BASE + 8'(off), 8'h00, tag);
  endtask

  initial begin
    rst            = 1'b1;
    bus_if.BUS_WE   = 1'b0;
    bus_if.BUS_ADDR = 8'h00;
    drv_oe         = 1'b0;
    drv_dat        = 8'h00;

    cyc(1'b1, 1'b0, 8'h00, 8'h00, "reset");
    cyc(1'b1, 1'b0, 8'h00, 8'h00, "reset");
    idle(20, "scan_after_reset");

    wr(0, 8'h21, "wr_d0");
    wr(1, 8'h43, "wr_d1");
    idle(20, "digits_1234");
    wr(0, 8'hFE, "wr_d0_fe");
    idle(16, "digits_fe");

    wr(2, 8'h05, "wr_dp");
    idle(16, "dp_mask");

    idle(1, "mid_digit");
    wr(3, 8'h00, "blank");
    idle(10, "blanked");
    wr(3, 8'h01, "unblank");
    idle(10, "resumed");

    rd(0, "rd_d0");
    rd(1, "rd_d1");
    rd(2, "rd_d2");
    rd(3, "rd_d3");
    rd(4, "rd_d4_oor");
    idle(2, "rd_tail");

    wr(0, 8'h5A, "wr_then_rd");
    rd(0, "wr_then_rd");
    idle(1, "wr_then_rd");
    wr(1, 8'h11, "b2b_wr");
    wr(1, 8'h22, "b2b_wr");
    rd(1, "b2b_rd");
    idle(1, "b2b_rd");
    cyc(1'b0, 1'b1, BASE - 8'd1, 8'h77, "oor_wr_low");
    cyc(1'b0, 1'b1, BASE + 8'd4, 8'h00, "oor_wr_high");
    rd(0, "oor_check");
    rd(3, "oor_check");
    idle(2, "oor_check");

    // Align so reset lands in the second cycle of digit2
    for (int k = 0; k < 8 * DT && !(((m_edges / DT) % 4) == 2 && (m_edges % DT) == 1); k++)
      idle(1, "align");
    cyc(1'b1, 1'b1, BASE, 8'hAB, "reset_vs_write");
    idle(1, "after_reset");
    rd(0, "after_reset_rd");
    idle(3, "after_reset");

    // Random traffic, including out-of-range addresses and occasional resets
    for (int i = 0; i < 1500; i++) begin
      int op;
      logic [7:0] a;
      op = int'($urandom_range(0, 9));
      a  = BASE - 8'd1 + 8'($urandom_range(0, 6));
      if ($urandom_range(0, 59) == 0) begin
        cyc(1'b1, (last_rd ? 1'b0 : 1'($urandom_range(0, 1))), a, 8'($urandom), "rand_reset");
        last_rd = 1'b0;
      end else if (op < 4 && !last_rd) begin
        cyc(1'b0, 1'b1, a, 8'($urandom), "rand_wr");
        last_rd = 1'b0;
      end else if (op < 7) begin
        cyc(1'b0, 1'b0, a, 8'h00, "rand_rd");
        last_rd = 1'b1;
      end else begin
        idle(1, "rand_idle");
        last_rd = 1'b0;
      end
    end
    idle(2, "final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
